// File: rtl/color_centroid_pkg.sv
// rtl/color_centroid_pkg.sv - shared widths and FSM state type for the color centroid block
package color_centroid_pkg;
  localparam int ROW_W      = 13;
  localparam int CNT_W      = 19;
  localparam int SUM_W      = 28;
  localparam int POS_W      = 10;
  localparam int DIV_CYCLES = 28;
  localparam int DIV_CNT_W  = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    ACCUM,
    DIV_X,
    DIV_Y,
    DONE
  } state_e;
endpackage

// File: rtl/color_centroid_if.sv
// rtl/color_centroid_if.sv - pixel stream in, frame result out
interface color_centroid_if;
  import color_centroid_pkg::*;

  logic             pix_valid;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] col;
  logic             i_color;
  logic             frame_end;
  logic [POS_W-1:0] centroid_x;
  logic [POS_W-1:0] centroid_y;
  logic [CNT_W-1:0] o_count;
  logic             o_found;
  logic             o_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output pix_valid, row, col, i_color, frame_end,
    input  centroid_x, centroid_y, o_count, o_found, o_valid, busy, overrun
  );

  modport slave (
    input  pix_valid, row, col, i_color, frame_end,
    output centroid_x, centroid_y, o_count, o_found, o_valid, busy, overrun
  );
endinterface

// File: rtl/color_centroid_seq_divider.sv
// rtl/color_centroid_seq_divider.sv - restoring divider, one quotient bit per cycle
module seq_divider
  import color_centroid_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic [POS_W-1:0] quotient_o,
  output logic             done_o,
  output logic             busy_o
);
  logic [SUM_W-1:0]     quo_q;
  logic [CNT_W-1:0]     rem_q;
  logic [CNT_W-1:0]     dsr_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [CNT_W:0]       shifted;
  logic [CNT_W-1:0]     diff;
  logic                 ge;

  // Remainder stays below the divisor, so the subtraction fits in CNT_W bits when ge.
  assign shifted = {rem_q, quo_q[SUM_W-1]};
  assign ge      = shifted >= {1'b0, dsr_q};
  assign diff    = shifted[CNT_W-1:0] - dsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dsr_q <= divisor_i;
      cnt_q <= DIV_CNT_W'(DIV_CYCLES);
    end else if (cnt_q != '0) begin
      quo_q <= {quo_q[SUM_W-2:0], ge};
      rem_q <= ge ? diff : shifted[CNT_W-1:0];
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // done flags the cycle whose closing edge retires the last quotient bit.
  assign done_o     = (cnt_q == DIV_CNT_W'(1));
  assign busy_o     = (cnt_q != '0);
  assign quotient_o = quo_q[POS_W-1:0];
endmodule

// File: rtl/color_centroid.sv
// rtl/color_centroid.sv - per-frame masked-pixel count and centroid via a shared divider
module color_centroid
  import color_centroid_pkg::*;
#(
  parameter int MIN_PIXELS = 64,
  parameter int ROW_MAX    = 477,
  parameter int COL_MAX    = 617
) (
  input logic             clk,
  input logic             reset,
  color_centroid_if.slave bus
);
  localparam logic [ROW_W-1:0] ROW_LIM = ROW_W'(ROW_MAX);
  localparam logic [ROW_W-1:0] COL_LIM = ROW_W'(COL_MAX);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, snap_cnt_q, o_count_q;
  logic [SUM_W-1:0] sx_q, sx_d, sy_q, sy_d, snap_sy_q;
  logic [POS_W-1:0] qx_q, cx_q, cy_q, quotient;
  logic             o_found_q, o_valid_q, overrun_q;
  logic             qual, accept, found;
  logic             div_start, div_done, div_busy;

  assign qual   = bus.pix_valid && bus.i_color && (bus.row <= ROW_LIM) && (bus.col <= COL_LIM);
  assign cnt_d  = cnt_q + CNT_W'(qual);
  assign sx_d   = sx_q + (qual ? SUM_W'(bus.col) : '0);
  assign sy_d   = sy_q + (qual ? SUM_W'(bus.row) : '0);
  assign accept = (state_q == ACCUM) && bus.frame_end;
  assign found  = snap_cnt_q >= MIN_CNT;

  // X division is loaded straight from the closing sums; Y is loaded on the first DIV_Y cycle.
  assign div_start = accept || ((state_q == DIV_Y) && !div_busy);

  seq_divider u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .dividend_i (accept ? sx_d : snap_sy_q),
    .divisor_i  (accept ? cnt_d : snap_cnt_q),
    .quotient_o (quotient),
    .done_o     (div_done),
    .busy_o     (div_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACCUM;
      cnt_q      <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      snap_cnt_q <= '0;
      snap_sy_q  <= '0;
      qx_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      o_count_q  <= '0;
      o_found_q  <= 1'b0;
      o_valid_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      overrun_q <= bus.frame_end && (state_q != ACCUM);
      if (bus.frame_end) begin
        cnt_q <= '0;
        sx_q  <= '0;
        sy_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        sx_q  <= sx_d;
        sy_q  <= sy_d;
      end
      case (state_q)
        ACCUM: begin
          if (accept) begin
            snap_cnt_q <= cnt_d;
            snap_sy_q  <= sy_d;
            state_q    <= DIV_X;
          end
        end
        DIV_X: begin
          if (div_done) state_q <= DIV_Y;
        end
        DIV_Y: begin
          if (!div_busy) qx_q <= quotient;
          else if (div_done) state_q <= DONE;
        end
        DONE: begin
          o_count_q <= snap_cnt_q;
          o_found_q <= found;
          if (found) begin
            cx_q <= qx_q;
            cy_q <= quotient;
          end
          o_valid_q <= 1'b1;
          state_q   <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.centroid_x = cx_q;
  assign bus.centroid_y = cy_q;
  assign bus.o_count    = o_count_q;
  assign bus.o_found    = o_found_q;
  assign bus.o_valid    = o_valid_q;
  assign bus.busy       = (state_q == DIV_X) || (state_q == DIV_Y);
  assign bus.overrun    = overrun_q;
endmodule

// File: doc/color_centroid.md
COLOR_CENTROID -- requirements
Module: color_centroid

Interface
REQ-001 SHALL have parameter MIN_PIXELS, default 64: minimum masked-pixel count for a valid detection.
REQ-002 SHALL have parameter ROW_MAX, default 477: last active row included.
REQ-003 SHALL have parameter COL_MAX, default 617: last active column included.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pix_valid  input  1  row/col/i_color valid this cycle.
REQ-007 row  input  13  pixel row.
REQ-008 col  input  13  pixel column.
REQ-009 i_color  input  1  per-pixel color-match bit from the HSV filter.
REQ-010 frame_end  input  1  one-cycle pulse marking the last pixel of a frame.
REQ-011 centroid_x  output  10  floor(sum col / count) of the last valid frame.
REQ-012 centroid_y  output  10  floor(sum row / count) of the last valid frame.
REQ-013 o_count  output  19  masked-pixel count of the last completed frame.
REQ-014 o_found  output  1  last completed frame had count >= MIN_PIXELS.
REQ-015 o_valid  output  1  one-cycle pulse: result outputs updated.
REQ-016 busy  output  1  divider in DIV_X or DIV_Y.
REQ-017 overrun  output  1  one-cycle pulse: frame result dropped.

Function
REQ-018 Pixel qualifies when pix_valid && i_color && row <= ROW_MAX && col <= COL_MAX.
REQ-019 Qualifying pixel adds 1 to cnt (19 b), col to sum_x (28 b), row to sum_y (28 b); no saturation needed, widths cover the full window.
REQ-020 Pixel presented in the same cycle as frame_end belongs to the ending frame.
REQ-021 On frame_end while state is ACCUM: snapshot cnt/sum_x/sum_y (including that cycle's pixel) into divider registers, clear accumulators, go to DIV_X; accumulation of the next frame starts the following cycle.
REQ-022 States: ACCUM -> DIV_X (28 cycles) -> DIV_Y (28 cycles) -> DONE (1 cycle) -> ACCUM.
REQ-023 Division SHALL be restoring, one quotient bit per cycle, 28-bit dividend by 19-bit divisor; the low 10 quotient bits are used.
REQ-024 In DONE: o_count <= snapshot cnt; o_found <= (cnt >= MIN_PIXELS); if found, centroid_x/centroid_y <= quotients, else both hold previous values; o_valid = 1.
REQ-025 Latency: o_valid SHALL be high in the cycle beginning 58 rising edges after the edge sampling frame_end, fixed regardless of count.
REQ-026 cnt == 0 SHALL run the same sequence; quotient is discarded, no divide-by-zero side effect.
REQ-027 frame_end while busy or in DONE: that frame's sums are discarded, accumulators cleared, overrun pulses for one cycle, and the in-flight division completes unaffected.
REQ-028 busy = 1 exactly in DIV_X and DIV_Y.
REQ-029 Pixel accumulation SHALL continue in every state.

Reset
REQ-030 Reset SHALL force state ACCUM, clear accumulators and divider registers, and set every output to 0.
REQ-031 Reset mid-division SHALL abort it; no o_valid for the aborted frame.
REQ-032 Reset has priority over frame_end and pixel input in the same cycle.

Structure
REQ-033 Package color_centroid_pkg SHALL hold the state enum, CNT_W=19, SUM_W=28, POS_W=10 and DIV_CYCLES=28.
REQ-034 Sub-module seq_divider SHALL implement the restoring divider (start, dividend, divisor -> quotient, done) and be instantiated once, reused for X then Y.

Verification
REQ-035 8x8 block, rows 100-107, cols 200-207, frame_end -> count 64, centroid_x 203, centroid_y 103, o_found 1, o_valid at +58.
REQ-036 Same block minus one pixel (63) -> o_found 0, o_count 63, centroids hold prior 203/103.
REQ-037 Full window all set -> o_count 295404, centroid_x 308, centroid_y 238.
REQ-038 Pixels at col 620 or row 480 only -> o_count 0, o_found 0.
REQ-039 Second frame_end 20 cycles after the first -> overrun pulse, first result correct, second frame dropped.
REQ-040 Reset 10 cycles into DIV_Y -> no o_valid, all outputs 0, next frame processes normally.
